mdi_sift_collector: RTL and testbench
=====================================

Name: mdi_sift_collector

Overview:
- Round sequencer and sifting stage directly downstream of the MDI register pair top.
- Per round, accepts one prepared value/basis set, provisions a fresh register pair, issues the one-cycle read strobe and samples the pad-gated outputs.
- Keeps matched-basis bytes as sifted key and accumulates bit errors (QBER numerator).
- Registers are single-shot because the kill latch is permanent, so each round targets a distinct pair selected by pair_sel.

Parameters:
NUM_PAIRS, 16, number of physical register pairs in the bank; also the maximum number of rounds
KEY_DEPTH, 8, sifted-key FIFO entries (8-bit each), power of two
ERR_THRESH, 12, abort when cumulative error bits exceed this value
ERR_W, 8, width of the error accumulator; saturating

Ports:
clk  in  1  clock
reset  in  1  reset; synchronous, active-high
start  in  1  begin a session; ignored while busy
num_rounds  in  $clog2(NUM_PAIRS)+1  rounds requested; values above NUM_PAIRS are clamped
prep_valid  in  1  prepared set available
prep_ready  out  1  collector accepts the prepared set
prep_value_a, prep_value_b  in  8 each  prepared values
prep_basis_a, prep_basis_b  in  2 each  prepared bases
pair_sel  out  $clog2(NUM_PAIRS)  target pair; external decode qualifies init and read
init  out  1  provisioning strobe to the pair top
read  out  1  read strobe to the pair top
value_a, value_b, basis_a, basis_b  out  8/8/2/2  registered prepared set driven to the pair top
out_a, out_b  in  8 each  pair outputs; LFSR garbage unless the corresponding pad enable is high
pad_enable_a, pad_enable_b  in  1 each  physical output enables from the pair top
key_valid  out  1  FIFO not empty
key_ready  in  1  consumer pop
key_data  out  8  FIFO head
busy  out  1  state is neither IDLE, DONE nor ABORT
done  out  1  level; session complete
abort  out  1  level; error threshold exceeded or tamper
tamper  out  1  sticky; exactly one pad enable was seen high
rounds_done  out  $clog2(NUM_PAIRS)+1  rounds executed
sifted_count  out  $clog2(NUM_PAIRS)+1  bytes pushed into the FIFO
err_bits  out  ERR_W  cumulative error bits

Behaviour:
- Reset value of every output is 0, including FIFO pointers. Reset mid-session returns to IDLE and deasserts init/read on the cycle after the edge.
- States: IDLE, WAIT_PREP, INIT, READ, CHECK, DONE, ABORT.
- IDLE / DONE / ABORT on start:
  - clear counters, err_bits, tamper, done and abort;
  - latch the clamped num_rounds; the FIFO is not flushed;
  - go to WAIT_PREP; if the clamped value is 0, go to DONE instead.
- WAIT_PREP:
  - prep_ready = 1 only while the FIFO is not full, so a READ always has space to push;
  - on prep_valid && prep_ready, register the set and go to INIT.
- INIT: init = 1 for exactly one cycle with pair_sel = rounds_done; then READ.
- READ: read = 1 for exactly one cycle; out_*/pad_enable_* are sampled combinationally in this cycle, before the edge. Outcomes:
  - both pad enables high: push out_a; sifted_count + 1; err_bits += popcount(out_a ^ out_b), saturating at all-ones;
  - neither high: basis mismatch; discard;
  - exactly one high: set tamper; nothing is pushed.
  - rounds_done increments in all three cases.
- CHECK:
  - tamper set, or err_bits > ERR_THRESH → ABORT;
  - else rounds_done == latched rounds → DONE;
  - else → WAIT_PREP.
- Minimum round latency is 4 cycles (WAIT_PREP handshake, INIT, READ, CHECK).
- DONE and ABORT hold their flag until the next start or reset.
- FIFO:
  - a push and a pop in the same cycle are both honoured; count is unchanged;
  - a pop while empty is ignored;
  - pointers wrap modulo KEY_DEPTH.

Decomposition:
- mdi_pkg holds:
  - the state enum (sift_state_t);
  - basis_t (logic [1:0]);
  - BYTE_W = 8;
  - popcount8 function.
- Sub-module mdi_key_fifo (synchronous FIFO, DEPTH and WIDTH parameters, full/empty/count outputs).

Test Plan:
- Matched bases, value 0x3C on both sides, num_rounds = 1 → exactly one init pulse, then one read pulse; FIFO holds 0x3C; err_bits = 0; done = 1 four cycles after the handshake.
- Bases 01 vs 10, num_rounds = 3 → FIFO empty; rounds_done = 3; sifted_count = 0; pair_sel steps 0,1,2.
- Matched bases, A = 0xFF, B = 0x00 twice with ERR_THRESH = 12 → err_bits = 16; abort after the second CHECK; no third prep_ready.
- Only pad_enable_a high in READ → tamper = 1 and abort = 1; FIFO unchanged.
- KEY_DEPTH = 8, 10 matched rounds, key_ready = 0 → prep_ready held low after 8 pushes; releasing key_ready resumes rounds; all 10 bytes are received in order.
- Reset asserted during INIT, and num_rounds = 0 → reset: all outputs 0 and IDLE next cycle; num_rounds = 0: DONE with no init pulse.

Source files
------------

// File: rtl/mdi_pkg.sv
// Shared types and helpers for the MDI sifting collector.
//   sift_state_t : collector FSM state encoding (localparam constants below)
//   basis_t      : two-bit measurement basis
//   BYTE_W       : width of a prepared value / sifted key byte
//   popcount8    : number of set bits in a byte
package mdi_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef logic [1:0] basis_t;
    typedef logic [2:0] sift_state_t;

    localparam sift_state_t StIdle     = 3'd0;
    localparam sift_state_t StWaitPrep = 3'd1;
    localparam sift_state_t StInit     = 3'd2;
    localparam sift_state_t StRead     = 3'd3;
    localparam sift_state_t StCheck    = 3'd4;
    localparam sift_state_t StDone     = 3'd5;
    localparam sift_state_t StAbort    = 3'd6;

    function automatic logic [3:0] popcount8(input logic [BYTE_W-1:0] x);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < BYTE_W; i++) begin
            n = n + {3'b000, x[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/mdi_key_fifo.sv
// Synchronous FIFO holding sifted key bytes.
// Ports:
//   clk, reset    : clock, synchronous active-high reset (clears pointers and count)
//   push, wdata   : write request and data; dropped when full unless a pop frees a slot
//   pop           : read request; ignored while empty
//   rdata         : head entry, 0 while empty
//   full, empty   : occupancy flags
//   count         : number of stored entries
module mdi_key_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign count   = count_q;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = empty ? '0 : mem[rptr_q];

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + AW'(1);
            if (do_pop)  rptr_q <= rptr_q + AW'(1);
            if (do_push && !do_pop)      count_q <= count_q + CW'(1);
            else if (do_pop && !do_push) count_q <= count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr_q] <= wdata;
    end

endmodule

// File: rtl/mdi_sift_collector.sv
// Round sequencer and sifting stage for the MDI register pair bank.
// Each round takes one prepared value/basis set, provisions a fresh pair (init), strobes
// read and sifts the pad-gated outputs: matched bases yield a key byte and error count,
// mismatched bases are discarded, a single pad enable flags tampering.
// Ports:
//   clk, reset                     : clock, synchronous active-high reset
//   start, num_rounds              : session start and requested rounds (clamped)
//   prep_valid/prep_ready, prep_*  : prepared set handshake
//   pair_sel, init, read           : pair addressing and strobes
//   value_a/b, basis_a/b           : registered prepared set for the pair top
//   out_a/b, pad_enable_a/b        : pair outputs and their physical enables
//   key_valid/key_ready/key_data   : sifted key FIFO read side
//   busy, done, abort, tamper      : session status
//   rounds_done, sifted_count, err_bits : session counters
module mdi_sift_collector
    import mdi_pkg::*;
#(
    parameter int unsigned NUM_PAIRS  = 16,
    parameter int unsigned KEY_DEPTH  = 8,
    parameter int unsigned ERR_THRESH = 12,
    parameter int unsigned ERR_W      = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [$clog2(NUM_PAIRS):0]   num_rounds,
    input  logic                         prep_valid,
    output logic                         prep_ready,
    input  logic [BYTE_W-1:0]            prep_value_a,
    input  logic [BYTE_W-1:0]            prep_value_b,
    input  basis_t                       prep_basis_a,
    input  basis_t                       prep_basis_b,
    output logic [$clog2(NUM_PAIRS)-1:0] pair_sel,
    output logic                         init,
    output logic                         read,
    output logic [BYTE_W-1:0]            value_a,
    output logic [BYTE_W-1:0]            value_b,
    output basis_t                       basis_a,
    output basis_t                       basis_b,
    input  logic [BYTE_W-1:0]            out_a,
    input  logic [BYTE_W-1:0]            out_b,
    input  logic                         pad_enable_a,
    input  logic                         pad_enable_b,
    output logic                         key_valid,
    input  logic                         key_ready,
    output logic [BYTE_W-1:0]            key_data,
    output logic                         busy,
    output logic                         done,
    output logic                         abort,
    output logic                         tamper,
    output logic [$clog2(NUM_PAIRS):0]   rounds_done,
    output logic [$clog2(NUM_PAIRS):0]   sifted_count,
    output logic [ERR_W-1:0]             err_bits
);

    localparam int unsigned PW  = $clog2(NUM_PAIRS);
    localparam int unsigned CW  = PW + 1;
    localparam int unsigned EW1 = ERR_W + 1;

    sift_state_t         state_q, state_d;
    logic [CW-1:0]       target_q, target_d;
    logic [CW-1:0]       rounds_q, rounds_d;
    logic [CW-1:0]       sifted_q, sifted_d;
    logic [ERR_W-1:0]    err_q, err_d;
    logic                tamper_q, tamper_d;
    logic [BYTE_W-1:0]   val_a_q, val_a_d, val_b_q, val_b_d;
    basis_t              bas_a_q, bas_a_d, bas_b_q, bas_b_d;

    logic                key_full, key_empty;
    logic [$clog2(KEY_DEPTH):0] key_count_unused;
    logic [CW-1:0]       clamped;
    logic                matched, lone_pad, over_thresh;
    logic [EW1-1:0]      err_sum;
    logic [ERR_W-1:0]    err_sat;

    assign clamped     = (num_rounds > CW'(NUM_PAIRS)) ? CW'(NUM_PAIRS) : num_rounds;
    assign matched     = pad_enable_a && pad_enable_b;
    assign lone_pad    = pad_enable_a ^ pad_enable_b;
    assign err_sum     = {1'b0, err_q} + EW1'(popcount8(out_a ^ out_b));
    assign err_sat     = err_sum[ERR_W] ? '1 : err_sum[ERR_W-1:0];
    assign over_thresh = (32'(err_q) > ERR_THRESH);

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        rounds_d = rounds_q;
        sifted_d = sifted_q;
        err_d    = err_q;
        tamper_d = tamper_q;
        val_a_d  = val_a_q;
        val_b_d  = val_b_q;
        bas_a_d  = bas_a_q;
        bas_b_d  = bas_b_q;
        case (state_q)
            StIdle, StDone, StAbort: begin
                if (start) begin
                    rounds_d = '0;
                    sifted_d = '0;
                    err_d    = '0;
                    tamper_d = 1'b0;
                    target_d = clamped;
                    state_d  = (clamped == '0) ? StDone : StWaitPrep;
                end
            end
            StWaitPrep: begin
                // Only accept a set when the FIFO can take this round's byte.
                if (prep_valid && !key_full) begin
                    val_a_d = prep_value_a;
                    val_b_d = prep_value_b;
                    bas_a_d = prep_basis_a;
                    bas_b_d = prep_basis_b;
                    state_d = StInit;
                end
            end
            StInit: state_d = StRead;
            StRead: begin
                rounds_d = rounds_q + CW'(1);
                if (matched) begin
                    sifted_d = sifted_q + CW'(1);
                    err_d    = err_sat;
                end else if (lone_pad) begin
                    tamper_d = 1'b1;
                end
                state_d = StCheck;
            end
            StCheck: begin
                if (tamper_q || over_thresh)   state_d = StAbort;
                else if (rounds_q == target_q) state_d = StDone;
                else                           state_d = StWaitPrep;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            target_q <= '0;
            rounds_q <= '0;
            sifted_q <= '0;
            err_q    <= '0;
            tamper_q <= 1'b0;
            val_a_q  <= '0;
            val_b_q  <= '0;
            bas_a_q  <= '0;
            bas_b_q  <= '0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            rounds_q <= rounds_d;
            sifted_q <= sifted_d;
            err_q    <= err_d;
            tamper_q <= tamper_d;
            val_a_q  <= val_a_d;
            val_b_q  <= val_b_d;
            bas_a_q  <= bas_a_d;
            bas_b_q  <= bas_b_d;
        end
    end

    mdi_key_fifo #(
        .DEPTH (KEY_DEPTH),
        .WIDTH (BYTE_W)
    ) u_key_fifo (
        .clk   (clk),
        .reset (reset),
        .push  ((state_q == StRead) && matched),
        .wdata (out_a),
        .pop   (key_ready),
        .rdata (key_data),
        .full  (key_full),
        .empty (key_empty),
        .count (key_count_unused)
    );

    assign prep_ready   = (state_q == StWaitPrep) && !key_full;
    assign init         = (state_q == StInit);
    assign read         = (state_q == StRead);
    assign pair_sel     = rounds_q[PW-1:0];
    assign value_a      = val_a_q;
    assign value_b      = val_b_q;
    assign basis_a      = bas_a_q;
    assign basis_b      = bas_b_q;
    assign key_valid    = !key_empty;
    assign busy         = !((state_q == StIdle) || (state_q == StDone) || (state_q == StAbort));
    assign done         = (state_q == StDone);
    assign abort        = (state_q == StAbort);
    assign tamper       = tamper_q;
    assign rounds_done  = rounds_q;
    assign sifted_count = sifted_q;
    assign err_bits     = err_q;

endmodule

// File: tb/tb_mdi_sift_collector.sv
// Scoreboard bench for mdi_sift_collector with a round-level reference model.
module tb_mdi_sift_collector;

    localparam int unsigned NP = 16;
    localparam int unsigned ET = 12;

    typedef struct {
        logic [7:0] va, vb, oa, ob;
        logic [1:0] ba, bb;
        logic       pa, pb;
    } round_t;

    logic       clk = 1'b0;
    logic       reset, start, prep_valid, prep_ready;
    logic [4:0] num_rounds, rounds_done, sifted_count;
    logic [7:0] prep_value_a, prep_value_b, value_a, value_b, out_a, out_b, key_data, err_bits;
    logic [1:0] prep_basis_a, prep_basis_b, basis_a, basis_b;
    logic [3:0] pair_sel;
    logic       init, read, pad_enable_a, pad_enable_b, key_valid, key_ready;
    logic       busy, done, abort, tamper;

    int unsigned checks = 0, failures = 0, cycle = 0, hs_cycle = 0, sess_init_cnt = 0;
    logic [7:0]  exp_q[$];
    round_t      cur;
    logic        hold_ready = 1'b0;

    mdi_sift_collector dut (
        .clk(clk), .reset(reset), .start(start), .num_rounds(num_rounds),
        .prep_valid(prep_valid), .prep_ready(prep_ready),
        .prep_value_a(prep_value_a), .prep_value_b(prep_value_b),
        .prep_basis_a(prep_basis_a), .prep_basis_b(prep_basis_b),
        .pair_sel(pair_sel), .init(init), .read(read),
        .value_a(value_a), .value_b(value_b), .basis_a(basis_a), .basis_b(basis_b),
        .out_a(out_a), .out_b(out_b), .pad_enable_a(pad_enable_a), .pad_enable_b(pad_enable_b),
        .key_valid(key_valid), .key_ready(key_ready), .key_data(key_data),
        .busy(busy), .done(done), .abort(abort), .tamper(tamper),
        .rounds_done(rounds_done), .sifted_count(sifted_count), .err_bits(err_bits)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic finish_now();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    endtask

    function automatic round_t mk(input logic [7:0] va, input logic [7:0] vb,
                                  input logic [1:0] ba, input logic [1:0] bb,
                                  input logic pa, input logic pb);
        round_t r;
        r.va = va; r.vb = vb; r.ba = ba; r.bb = bb; r.pa = pa; r.pb = pb;
        r.oa = va; r.ob = vb;
        return r;
    endfunction

    // Pair behaviour: outputs valid only on matched bases, garbage otherwise;
    // occasional bit errors and occasional single-pad tamper.
    function automatic round_t rnd();
        round_t r;
        r.va = 8'($urandom);
        r.vb = r.va;
        if ($urandom_range(0, 3) == 0) r.vb = r.va ^ (8'h01 << $urandom_range(0, 7));
        r.ba = 2'($urandom);
        r.bb = 2'($urandom);
        r.pa = (r.ba == r.bb);
        r.pb = r.pa;
        if ($urandom_range(0, 19) == 0) r.pb = ~r.pa;
        r.oa = r.pa ? r.va : 8'($urandom);
        r.ob = r.pb ? r.vb : 8'($urandom);
        return r;
    endfunction

    // Consumer: random pops unless held off.
    initial begin
        key_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            key_ready = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: key scoreboard plus strobe timing/addressing.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (key_valid && key_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL key_extra: got 0x%0h expected no byte", key_data);
                    end else begin
                        chk("key_data", key_data, exp_q.pop_front());
                    end
                end
                if (prep_valid && prep_ready) hs_cycle = cycle;
                if (init) begin
                    chk("init_latency", cycle, hs_cycle + 1);
                    chk("pair_sel", pair_sel, sess_init_cnt);
                    chk("regd_set", {value_a, value_b, basis_a, basis_b},
                        {cur.va, cur.vb, cur.ba, cur.bb});
                    chk("init_read_excl", read, 0);
                    sess_init_cnt++;
                end
                if (read) chk("read_latency", cycle, hs_cycle + 2);
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    // Tasks start and end at posedge + 1.
    task automatic offer(input round_t r);
        int n;
        cur = r;
        prep_valid = 1'b1;
        prep_value_a = r.va; prep_value_b = r.vb;
        prep_basis_a = r.ba; prep_basis_b = r.bb;
        n = 0;
        forever begin
            @(negedge clk);
            if (prep_ready) break;
            n++;
            if (n > 300) begin
                checks++;
                failures++;
                $display("FAIL prep_ready_wait: got 0 expected 1 within 300 cycles");
                finish_now();
            end
        end
        @(posedge clk);
        #1;
        prep_valid = 1'b0;
        out_a = r.oa; out_b = r.ob;
        pad_enable_a = r.pa; pad_enable_b = r.pb;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic session(input int unsigned n_req, input round_t rs[$]);
        int unsigned tgt, err, rd, sc, n;
        bit tam, ab;
        tgt = (n_req > NP) ? NP : n_req;
        err = 0; rd = 0; sc = 0; tam = 0; ab = 0;
        for (int i = 0; i < int'(tgt); i++) begin
            rd++;
            if (rs[i].pa && rs[i].pb) begin
                sc++;
                exp_q.push_back(rs[i].oa);
                err += $countones(rs[i].oa ^ rs[i].ob);
                if (err > 255) err = 255;
            end else if (rs[i].pa != rs[i].pb) begin
                tam = 1;
            end
            if (tam || err > ET) begin
                ab = 1;
                break;
            end
        end
        sess_init_cnt = 0;
        num_rounds = 5'(n_req);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("start_clear", {tamper, err_bits, rounds_done, sifted_count}, 0);
        for (int i = 0; i < int'(rd); i++) offer(rs[i]);
        n = 0;
        forever begin
            @(negedge clk);
            if (done || abort) break;
            n++;
            if (n > 100) break;
        end
        chk("done", done, !ab);
        chk("abort", abort, ab);
        chk("tamper", tamper, tam);
        chk("rounds_done", rounds_done, rd);
        chk("sifted_count", sifted_count, sc);
        chk("err_bits", err_bits, err);
        chk("idle_ports", {busy, prep_ready, init, read}, 0);
        chk("init_count", sess_init_cnt, rd);
        if (rd > 0) chk("end_latency", cycle, hs_cycle + 4);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain", exp_q.size(), 0);
        chk("fifo_empty", key_valid, 0);
    endtask

    initial begin
        round_t rs[$];
        reset = 1'b1; start = 1'b0; num_rounds = '0; prep_valid = 1'b0;
        prep_value_a = '0; prep_value_b = '0; prep_basis_a = '0; prep_basis_b = '0;
        out_a = '0; out_b = '0; pad_enable_a = 1'b0; pad_enable_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {prep_ready, pair_sel, init, read, value_a, value_b, basis_a,
            basis_b, key_valid, key_data, busy, done, abort, tamper, rounds_done,
            sifted_count, err_bits}, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Matched 0x3C, single round.
        rs = {};
        rs.push_back(mk(8'h3C, 8'h3C, 2'b01, 2'b01, 1'b1, 1'b1));
        session(1, rs);

        // Basis mismatch, three rounds.
        rs = {};
        for (int i = 0; i < 3; i++) rs.push_back(mk(8'($urandom), 8'($urandom), 2'b01, 2'b10, 1'b0, 1'b0));
        session(3, rs);

        // 8 errors per round: abort after the second round.
        rs = {};
        for (int i = 0; i < 4; i++) rs.push_back(mk(8'hFF, 8'h00, 2'b00, 2'b00, 1'b1, 1'b1));
        session(4, rs);
        repeat (3) @(posedge clk);
        #1;
        chk("no_third_ready", prep_ready, 0);

        // Single pad enable: tamper.
        rs = {};
        rs.push_back(mk(8'h55, 8'h55, 2'b10, 2'b10, 1'b1, 1'b0));
        rs.push_back(mk(8'h66, 8'h66, 2'b10, 2'b10, 1'b1, 1'b1));
        session(2, rs);

        // FIFO backpressure: 10 matched rounds with the consumer stalled.
        drain();
        hold_ready = 1'b1;
        rs = {};
        for (int i = 0; i < 10; i++) begin
            logic [7:0] v;
            v = 8'($urandom);
            rs.push_back(mk(v, v, 2'b11, 2'b11, 1'b1, 1'b1));
        end
        fork
            session(10, rs);
            begin
                repeat (80) @(posedge clk);
                #1;
                chk("stall_rounds", rounds_done, 8);
                chk("stall_ready", prep_ready, 0);
                chk("stall_sifted", sifted_count, 8);
                hold_ready = 1'b0;
            end
        join

        // Reset during INIT, then a zero-round session.
        drain();
        sess_init_cnt = 0;
        num_rounds = 5'd1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        rs = {};
        rs.push_back(mk(8'hA5, 8'hA5, 2'b00, 2'b00, 1'b1, 1'b1));
        cur = rs[0];
        prep_valid = 1'b1;
        prep_value_a = 8'hA5; prep_value_b = 8'hA5; prep_basis_a = '0; prep_basis_b = '0;
        @(posedge clk);
        #1;
        prep_valid = 1'b0;
        chk("pre_reset_init", init, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_reset_outputs", {prep_ready, pair_sel, init, read, value_a, value_b, basis_a,
            basis_b, key_valid, busy, done, abort, tamper, rounds_done, sifted_count,
            err_bits}, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        session(0, rs);

        // Randomized sessions, including clamped round counts.
        for (int s = 0; s < 10; s++) begin
            rs = {};
            for (int i = 0; i < 20; i++) rs.push_back(rnd());
            session($urandom_range(0, 20), rs);
        end

        drain();
        finish_now();
    end

endmodule
